// File: rtl/uart_rx_buf_ctrl.sv
// Circular-buffer controller between a UART receiver and a 64x8 single-port RAM.
// Optional almost_full watermark output is enabled by defining UART_RXBUF_WATERMARK_EN.
module uart_rx_buf_ctrl #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter int CLR_CYCLES = 65
`ifdef UART_RXBUF_WATERMARK_EN
  ,
  parameter int WATERMARK  = 48
`endif
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rd_req,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              flush,
  input  logic              overrun_clr,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overrun,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr_en,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_clear,
  input  logic [DATA_W-1:0] ram_data_out,
`ifdef UART_RXBUF_WATERMARK_EN
  output logic              almost_full,
`endif
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CLR_W = $clog2(CLR_CYCLES);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    CLR_REQ  = 2'd2,
    CLR_WAIT = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [CLR_W-1:0]    clr_cnt;
  logic [DATA_W-1:0]   pend_data;
  logic                pend_valid;
  logic                rd_pend;
  logic [CNT_W-1:0]    count_nxt;

  logic wr_fire;
  logic rd_issue;
  logic rd_done;
  logic flush_take;
  logic rx_drop;

  // Valid/ready: a consumer read is accepted on a rising edge where rd_req && rd_ready;
  // the byte comes back later as a single-cycle rd_valid strobe with rd_data.
  assign busy       = (state == CLR_REQ) || (state == CLR_WAIT);
  assign empty      = (count == '0);
  assign full       = (count == DEPTH_C);
  assign rd_ready   = (state == IDLE) && !empty && !rd_pend;
  assign wr_fire    = pend_valid && !full && ((state == IDLE) || (state == RD_WAIT));
  assign rd_issue   = (state == IDLE) && !wr_fire && rd_pend && !empty;
  assign rd_done    = (state == RD_WAIT);
  assign flush_take = flush && !busy;
  assign rx_drop    = rx_valid && pend_valid && !wr_fire && !flush_take;

  // The RAM port idles as a read of rd_ptr; a write borrows it only when pend drains.
  assign ram_wr_en   = wr_fire;
  assign ram_addr    = wr_fire ? wr_ptr : rd_ptr;
  assign ram_data_in = pend_data;
  assign ram_clear   = (state == CLR_REQ);
  assign dbg_state   = state;

  always_comb begin
    count_nxt = count;
    if (!flush_take) begin
      if ((state == CLR_WAIT) && (clr_cnt == CLR_LAST)) begin
        count_nxt = '0;
      end else if (wr_fire && !rd_done) begin
        count_nxt = count + CNT_W'(1);
      end else if (!wr_fire && rd_done) begin
        count_nxt = count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      clr_cnt    <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      rd_pend    <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RXBUF_WATERMARK_EN
      almost_full <= 1'b0;
`endif
    end else begin
      count    <= count_nxt;
      rd_valid <= 1'b0;

      // A byte arriving while pend drains simply replaces the drained one.
      if (flush_take) begin
        pend_valid <= 1'b0;
      end else if (rx_valid && !rx_drop) begin
        pend_data  <= rx_data;
        pend_valid <= 1'b1;
      end else if (wr_fire) begin
        pend_valid <= 1'b0;
      end

      if (flush_take) begin
        overrun <= 1'b0;
      end else if (rx_drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end

      if (flush_take) begin
        rd_pend <= 1'b0;
      end else if (rd_req && rd_ready) begin
        rd_pend <= 1'b1;
      end else if (rd_done) begin
        rd_pend <= 1'b0;
      end

`ifdef UART_RXBUF_WATERMARK_EN
      almost_full <= (flush_take || busy) ? 1'b0 : (count_nxt >= CNT_W'(WATERMARK));
`endif

      if (flush_take) begin
        state <= CLR_REQ;
      end else begin
        if (wr_fire) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
        end
        case (state)
          IDLE: begin
            if (rd_issue) begin
              state <= RD_WAIT;
            end
          end
          RD_WAIT: begin
            rd_data  <= ram_data_out;
            rd_valid <= 1'b1;
            rd_ptr   <= rd_ptr + ADDR_W'(1);
            state    <= IDLE;
          end
          CLR_REQ: begin
            clr_cnt <= '0;
            state   <= CLR_WAIT;
          end
          CLR_WAIT: begin
            if (clr_cnt == CLR_LAST) begin
              wr_ptr <= '0;
              rd_ptr <= '0;
              state  <= IDLE;
            end else begin
              clr_cnt <= clr_cnt + CLR_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// Bench for uart_rx_buf_ctrl: RAM model, directed scenarios, randomized traffic,
// and a scoreboard that checks every RAM write and every consumer read.
module tb_uart_rx_buf_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rd_req = 1'b0;
  logic       flush = 1'b0;
  logic       overrun_clr = 1'b0;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [6:0] count;
  logic       empty, full, overrun, busy;
  logic [5:0] ram_addr;
  logic       ram_wr_en;
  logic [7:0] ram_data_in;
  logic       ram_clear;
  logic [7:0] ram_data_out = '0;
  logic [1:0] dbg_state;

  uart_rx_buf_ctrl dut (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .flush(flush), .overrun_clr(overrun_clr), .count(count), .empty(empty),
    .full(full), .overrun(overrun), .busy(busy), .ram_addr(ram_addr),
    .ram_wr_en(ram_wr_en), .ram_data_in(ram_data_in), .ram_clear(ram_clear),
    .ram_data_out(ram_data_out), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // 64x8 RAM with registered read data; clear zero-fills
  logic [7:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = '0;
  always @(posedge clock) begin
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (ram_wr_en) begin
      mem[ram_addr] <= ram_data_in;
    end else begin
      ram_data_out <= mem[ram_addr];
    end
  end

  // scoreboard
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] wq[$];
  int         exp_wr_addr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rd_unexpected: got rd_data %0h, expected no read", rd_data);
        end else begin
          check("rd_data", rd_data, exp_q.pop_front());
        end
      end
      if (ram_wr_en) begin
        check("wr_addr", ram_addr, exp_wr_addr);
        exp_wr_addr = (exp_wr_addr + 1) % 64;
        check("wr_not_busy", busy, 0);
        if (wq.size() == 0) begin
          n_checks++;
          $display("FAIL wr_unexpected: got write %0h, expected no write", ram_data_in);
        end else begin
          check("wr_data", ram_data_in, wq.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input bit kept);
    rx_valid = 1'b1;
    rx_data  = b;
    if (kept) begin
      exp_q.push_back(b);
      wq.push_back(b);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic read_one();
    int n = 0;
    while (!rd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!rd_ready) begin
      n_checks++;
      $display("FAIL rd_ready_timeout: rd_ready=%0b after %0d cycles, expected 1", rd_ready, n);
    end else begin
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
    end
  endtask

  task automatic model_flush();
    exp_q.delete();
    wq.delete();
    exp_wr_addr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_busy;
    int guard;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_ram_wr_en", ram_wr_en, 0);
    check("rst_ram_clear", ram_clear, 0);
    reset_n = 1'b1;
    tick();

    // single byte and read latency
    send(8'hA5, 1'b1);
    tick();
    check("single_count", count, 1);
    check("single_rd_ready", rd_ready, 1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("lat_c1_rd_valid", rd_valid, 0);
    tick();
    check("lat_c2_rd_valid", rd_valid, 0);
    tick();
    check("lat_c3_rd_valid", rd_valid, 1);
    check("single_count_after", count, 0);
    check("single_empty_after", empty, 1);
    check("empty_rd_ready", rd_ready, 0);

    // simultaneous ingress while the read-wait write slot is used
    for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b1);
    idle(3);
    check("sim_count_before", count, 5);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    send(8'h71, 1'b1);
    send(8'h72, 1'b1);
    check("sim_rd_valid", rd_valid, 1);
    check("sim_count_same", count, 5);
    check("sim_overrun", overrun, 0);
    tick();
    check("sim_count_next", count, 6);

    // flush with count=10, byte arrives mid-clear
    for (int i = 0; i < 4; i++) send(8'($urandom), 1'b1);
    idle(3);
    check("flush_count_before", count, 10);
    flush = 1'b1;
    model_flush();
    tick();
    flush = 1'b0;
    check("clr_pulse", ram_clear, 1);
    n_busy = 0;
    while (busy && n_busy < 200) begin
      n_busy++;
      if (n_busy == 2) check("clr_one_cycle", ram_clear, 0);
      if (n_busy == 20) begin
        rx_valid = 1'b1;
        rx_data  = 8'h5C;
        exp_q.push_back(8'h5C);
        wq.push_back(8'h5C);
      end else begin
        rx_valid = 1'b0;
      end
      tick();
    end
    rx_valid = 1'b0;
    check("busy_cycles", n_busy, 65);
    check("clr_count", count, 0);
    check("clr_empty", empty, 1);
    tick();
    check("clr_pend_written", count, 1);
    read_one();
    idle(4);
    check("clr_read_empty", empty, 1);

    // wrap
    for (int i = 0; i < 40; i++) send(8'($urandom), 1'b1);
    repeat (40) read_one();
    for (int i = 0; i < 40; i++) send(8'($urandom), 1'b1);
    idle(2);
    check("wrap_count", count, 40);
    repeat (40) read_one();
    idle(4);
    check("wrap_empty", empty, 1);

    // fill, hold, overrun
    for (int i = 0; i < 64; i++) send(8'(i), 1'b1);
    idle(2);
    check("fill_full", full, 1);
    check("fill_count", count, 64);
    send(8'h40, 1'b1);
    check("hold_overrun", overrun, 0);
    send(8'h41, 1'b0);
    check("drop_overrun", overrun, 1);
    read_one();
    idle(4);
    check("refill_count", count, 64);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_clr", overrun, 0);
    repeat (64) read_one();
    idle(4);
    check("fill_drained", empty, 1);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rx_valid = (exp_q.size() < 60) && ($urandom_range(0, 1) == 1);
      rx_data  = 8'($urandom);
      if (rx_valid) begin
        exp_q.push_back(rx_data);
        wq.push_back(rx_data);
      end
      rd_req      = rd_ready && ($urandom_range(0, 2) == 0);
      overrun_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    rx_valid    = 1'b0;
    overrun_clr = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 3000) begin
      rd_req = rd_ready;
      tick();
      guard++;
    end
    rd_req = 1'b0;
    idle(5);
    check("rand_left", exp_q.size(), 0);
    check("rand_count", count, 0);
    check("rand_overrun", overrun, 0);

    // async reset mid-clear
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b1);
    idle(3);
    flush = 1'b1;
    model_flush();
    tick();
    flush = 1'b0;
    idle(30);
    check("arst_busy_before", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_ram_clear", ram_clear, 0);
    check("arst_rd_ready", rd_ready, 0);
    tick();
    reset_n = 1'b1;
    model_flush();
    tick();
    send(8'h3C, 1'b1);
    read_one();
    idle(4);
    check("arst_after_empty", empty, 1);
    check("arst_after_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_buf_ctrl.md
Name: uart_rx_buf_ctrl

Overview:
- Buffer controller between the UART receiver and the 64x8 single-port RAM.
- Accepts received bytes, writes them into the RAM as a circular buffer, and serves them to the consumer through a request/valid read port.
- Reports buffer status (count, empty, full, overrun).
- Drives the RAM clear sequence on flush and holds off all access while the RAM is clearing.

Parameters:
- ADDR_W, 6, RAM address width; buffer depth is 2**ADDR_W = 64.
- DATA_W, 8, byte width.
- CLR_CYCLES, 65, RAM busy cycles per clear: 1 request cycle + 64 clearing cycles.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- rd_req  in  1  consumer read request; accepted only when rd_ready=1.
- rd_ready  out  1  = (state==IDLE) && count!=0 && !rd_pend.
- rd_data  out  8  byte returned to the consumer.
- rd_valid  out  1  one-cycle strobe; rd_data is valid.
- flush  in  1  one-cycle pulse; empties the buffer and zero-fills the RAM.
- overrun_clr  in  1  clears the overrun flag.
- count  out  7  bytes held in RAM, 0..64.
- empty  out  1  count==0.
- full  out  1  count==64.
- overrun  out  1  sticky; a received byte was dropped.
- busy  out  1  clear sequence in progress.
- ram_addr  out  6  RAM address.
- ram_wr_en  out  1  1 = write, 0 = read.
- ram_data_in  out  8  RAM write data.
- ram_clear  out  1  RAM clear request.
- ram_data_out  in  8  RAM registered read data, valid one cycle after a read cycle.

Behaviour:
- Reset (async, reset_n=0):
  - wr_ptr=0, rd_ptr=0, count=0.
  - pend_valid=0, rd_pend=0, rd_data=0, rd_valid=0, overrun=0.
  - state=IDLE, ram_clear=0, ram_wr_en=0.
  - Reset asserted mid-clear aborts the clear with no recovery; the RAM contents are don't-care.
- RAM outputs are combinational from the current state and registers. The default cycle is a read (ram_wr_en=0, ram_addr=rd_ptr, ram_clear=0).
- Ingress:
  - rx_valid loads a one-entry holding register (pend_data, pend_valid=1).
  - If pend_valid is already 1 and is not being drained this cycle, the new byte is dropped and overrun is set.
  - Draining pend and accepting a new byte in the same cycle is legal: the new byte replaces the drained one.
- States:
  - IDLE:
    - If pend_valid && !full: write cycle (ram_wr_en=1, ram_addr=wr_ptr, ram_data_in=pend_data); wr_ptr++ (wraps 63->0); pend_valid=0; count++.
    - Else if rd_pend && !empty: read cycle at rd_ptr; go to RD_WAIT.
  - RD_WAIT:
    - Capture ram_data_out into rd_data; rd_valid=1 next cycle; rd_ptr++ (wraps); count--; rd_pend=0; go to IDLE.
    - A pending write may be issued in the same cycle. If so, count is unchanged.
  - CLR_REQ: ram_clear=1 for exactly one cycle; go to CLR_WAIT.
  - CLR_WAIT: wait 64 cycles on a clr_cnt counter; then wr_ptr=rd_ptr=0, count=0; go to IDLE.
- Read latency: rd_req accepted in cycle 0 -> read issued in cycle 1 -> rd_valid in cycle 3. A pending write in cycle 1 delays this by one cycle.
- Priority: write over read. Reads are never starved, because at most one write is pending at a time.
- Full: pend is held and no write is issued. Reads proceed, and the next IDLE cycle writes pend.
- Empty: rd_ready=0, and rd_req is ignored.
- Flush:
  - Taken from any state at the next edge.
  - A read in RD_WAIT is dropped; no rd_valid is produced.
  - pend_valid, rd_pend and overrun are cleared.
  - busy=1 from CLR_REQ through the final CLR_WAIT cycle (65 cycles).
  - During busy, no RAM read or write is issued, and rx_valid still loads pend. Flush during busy is ignored.
- overrun_clr clears overrun. If a drop occurs in the same cycle, set wins.

Optional Feature:
- Macro: UART_RXBUF_WATERMARK_EN.
- Defined:
  - Adds parameter WATERMARK (default 48).
  - Adds output almost_full (1 bit), registered, asserted when count >= WATERMARK; deasserts on flush.
- Undefined: neither the parameter nor the port exists; all other behaviour is identical.

Test Plan:
- Reset then single byte: rx_valid with 0xA5 -> count=1 two cycles later. Pulse rd_req -> rd_valid with rd_data=0xA5 three cycles after rd_req; count=0, empty=1.
- Fill: 64 bytes 0x00..0x3F -> full=1, count=64. A 65th byte is held in pend; a 66th -> overrun=1. One read returns 0x00, then pend is written; count=64.
- Wrap: write 40 bytes, read 40, write 40 more -> wr_ptr wraps to 16. Reads return the second batch in order.
- Simultaneous: rx_valid in the same cycle the RD_WAIT write slot is used -> count unchanged and data order preserved.
- Flush with count=10 -> ram_clear high for 1 cycle, busy high for 65 cycles, then count=0 and empty=1. A byte arriving mid-clear is written at address 0 after busy falls.
- Async reset asserted mid-CLR_WAIT -> all outputs return to reset values immediately, without waiting for a clock edge.
